clap_seq_ctrl: RTL and testbench

- Round-robin sequencer that shares one clap_delay flag detector between N_REQ requesters.
- Drives the detector's en/din_rvs pair only from registered outputs, and always changes din_rvs one full cycle before en rises, so the detector never sees the en/data race.
- Waits the detector's fixed latency, samples its flag, and returns the result to the granted requester with a one-cycle done pulse.

---
 rtl/clap_seq_ctrl_if.sv | 24 ++
 rtl/clap_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clap_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/clap_seq_ctrl_if.sv
// Requester and detector signal bundle for clap_seq_ctrl.
// slave = sequencer view, master = requesters plus detector view.
interface clap_seq_ctrl_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_din;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic             result;
    logic             en;
    logic             din_rvs;
    logic             flag;

    modport slave (
        input  req, req_din, flag,
        output gnt, done, result, en, din_rvs
    );

    modport master (
        output req, req_din, flag,
        input  gnt, done, result, en, din_rvs
    );
endinterface

// File: rtl/clap_seq_ctrl.sv
// clap_seq_ctrl: round-robin sequencer sharing one clap_delay flag detector among N_REQ requesters.
// Optional macro CLAP_SEQ_FLAG_SYNC_EN: 2-flop flag synchronizer, WAIT count grows to LAT+1.
module clap_seq_ctrl #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    clap_seq_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
`ifdef CLAP_SEQ_FLAG_SYNC_EN
    localparam int CNT_LOAD = LAT + 1;
    localparam int CNT_W    = $clog2(LAT + 2);
`else
    localparam int CNT_LOAD = LAT - 1;
    localparam int CNT_W    = $clog2(LAT + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ARM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             din_lat_q, din_lat_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [N_REQ-1:0] done_q,    done_d;
    logic             result_q,  result_d;
    logic             en_q,      en_d;
    logic             din_rvs_q, din_rvs_d;

    logic             flag_use;

`ifdef CLAP_SEQ_FLAG_SYNC_EN
    logic flag_s1_q;
    logic flag_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_s1_q <= 1'b0;
            flag_s2_q <= 1'b0;
        end else begin
            flag_s1_q <= bus.flag;
            flag_s2_q <= flag_s1_q;
        end
    end

    assign flag_use = flag_s2_q;
`else
    assign flag_use = bus.flag;
`endif

    // Round-robin pick: first set request strictly after ptr, wrapping modulo N_REQ.
    logic             found;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            pos = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(N_REQ)) begin
                pos = pos - (IDX_W + 1)'(N_REQ);
            end
            cand = pos[IDX_W-1:0];
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        din_lat_d = din_lat_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        result_d  = result_q;
        en_d      = en_q;
        din_rvs_d = din_rvs_q;

        unique case (state_q)
            S_IDLE: begin
                en_d      = 1'b0;
                din_rvs_d = 1'b1;
                if (found) begin
                    idx_d     = sel;
                    din_lat_d = bus.req_din[sel];
                    gnt_d     = N_REQ'(1) << sel;
                    state_d   = S_SETUP;
                end
            end
            // Data moves a full cycle ahead of en so the detector never races them.
            S_SETUP: begin
                din_rvs_d = din_lat_q;
                state_d   = S_ARM;
            end
            S_ARM: begin
                en_d    = 1'b1;
                cnt_d   = CNT_W'(CNT_LOAD);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = flag_use;
                    done_d   = N_REQ'(1) << idx_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                en_d      = 1'b0;
                din_rvs_d = 1'b1;
                gnt_d     = '0;
                done_d    = '0;
                ptr_d     = idx_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            idx_q     <= '0;
            din_lat_q <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= 1'b0;
            en_q      <= 1'b0;
            din_rvs_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            din_lat_q <= din_lat_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            en_q      <= en_d;
            din_rvs_q <= din_rvs_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.en      = en_q;
    assign bus.din_rvs = din_rvs_q;

endmodule

// File: tb/tb_clap_seq_ctrl.sv
// Bench for clap_seq_ctrl: vector table, scoreboard queue and hand-written corner sequences.
// Detector model: flag = en & ~din_rvs, valid to be sampled LAT edges after en rises.
module tb_clap_seq_ctrl;

    localparam int N   = 4;
    localparam int LAT = 2;
`ifdef CLAP_SEQ_FLAG_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif
    localparam int TXN = LAT + 4 + SX;

    typedef struct packed {
        logic [N-1:0] done;
        logic         res;
    } sb_t;

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] din;
        logic [N-1:0] gnt;
        logic         res;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic det_q;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    sb_t  sb_q[$];
    sb_t  mon_e;
    logic prev_din = 1'b1;
    vec_t vt[8];

    clap_seq_ctrl_if #(.N_REQ(N)) bus ();

    clap_seq_ctrl #(.N_REQ(N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // One register from en/din to flag: valid for the sampling edge E2+LAT when LAT=2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_q <= 1'b0;
        else        det_q <= bus.en & ~bus.din_rvs;
    end
    assign bus.flag = det_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (bus.done == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (bus.done == '0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no done within 40 cycles, required a done pulse", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done != '0) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got done=%b required no pulse", bus.done);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_done", 32'(bus.done), 32'(mon_e.done));
                chk("sb_result", 32'(bus.result), 32'(mon_e.res));
                chk("done_onehot", 32'($countones(bus.done)), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.en) chk("din_stable_en", 32'(bus.din_rvs), 32'(prev_din));
        prev_din = bus.din_rvs;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int   last;
        logic [N-1:0] exp_oh;

        vt[0] = '{req: 4'b0001, din: 4'b0000, gnt: 4'b0001, res: 1'b1};
        vt[1] = '{req: 4'b0001, din: 4'b0001, gnt: 4'b0001, res: 1'b0};
        vt[2] = '{req: 4'b0110, din: 4'b0010, gnt: 4'b0010, res: 1'b0};
        vt[3] = '{req: 4'b0110, din: 4'b0010, gnt: 4'b0100, res: 1'b1};
        vt[4] = '{req: 4'b1001, din: 4'b0001, gnt: 4'b1000, res: 1'b1};
        vt[5] = '{req: 4'b1001, din: 4'b1000, gnt: 4'b0001, res: 1'b1};
        vt[6] = '{req: 4'b1010, din: 4'b1010, gnt: 4'b0010, res: 1'b0};
        vt[7] = '{req: 4'b0001, din: 4'b1110, gnt: 4'b0001, res: 1'b1};

        bus.req     = '0;
        bus.req_din = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_din_rvs", 32'(bus.din_rvs), 32'd1);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            bus.req     = vt[v].req;
            bus.req_din = vt[v].din;
            sb_q.push_back('{done: vt[v].gnt, res: vt[v].res});
            @(negedge clk);
            chk("v_gnt", 32'(bus.gnt), 32'(vt[v].gnt));
            chk("v_setup_en", 32'(bus.en), 32'd0);
            chk("v_setup_din", 32'(bus.din_rvs), 32'd1);
            bus.req_din = ~vt[v].din;
            @(negedge clk);
            chk("v_arm_din", 32'(bus.din_rvs), 32'(|(vt[v].din & vt[v].gnt)));
            chk("v_arm_en", 32'(bus.en), 32'd0);
            @(negedge clk);
            chk("v_wait_en", 32'(bus.en), 32'd1);
            repeat (1 + SX) begin
                @(negedge clk);
                chk("v_no_early_done", 32'(bus.done), 32'd0);
            end
            @(negedge clk);
            chk("v_done", 32'(bus.done), 32'(vt[v].gnt));
            bus.req = '0;
            @(negedge clk);
            chk("v_idle_en", 32'(bus.en), 32'd0);
            chk("v_idle_din", 32'(bus.din_rvs), 32'd1);
            chk("v_idle_gnt", 32'(bus.gnt), 32'd0);
            chk("v_idle_done", 32'(bus.done), 32'd0);
            chk("v_result_held", 32'(bus.result), 32'(vt[v].res));
        end

        // All four requesters held: order 0,1,2,3,0 at fixed spacing.
        do_reset();
        bus.req     = 4'b1111;
        bus.req_din = 4'b0000;
        for (int k = 0; k < 5; k++) sb_q.push_back('{done: 4'b0001 << (k % 4), res: 1'b1});
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr_wait");
            exp_oh = 4'b0001 << (k % 4);
            chk("rr_done", 32'(bus.done), 32'(exp_oh));
            chk("rr_gnt", 32'(bus.gnt), 32'(exp_oh));
            if (k > 0) chk("rr_spacing", 32'(cyc - last), 32'(TXN));
            last = cyc;
            if (k == 4) bus.req = '0;
            @(negedge clk);
        end

        // Request dropped mid-WAIT still completes; then ptr=2 wraps to 0.
        bus.req = 4'b0100;
        sb_q.push_back('{done: 4'b0100, res: 1'b1});
        repeat (3) @(negedge clk);
        bus.req = '0;
        wait_done("drop_wait");
        chk("drop_done", 32'(bus.done), 32'h4);
        @(negedge clk);
        bus.req = 4'b0101;
        sb_q.push_back('{done: 4'b0001, res: 1'b1});
        @(negedge clk);
        chk("wrap_gnt", 32'(bus.gnt), 32'h1);
        wait_done("wrap_wait");
        chk("wrap_done", 32'(bus.done), 32'h1);
        bus.req = '0;
        @(negedge clk);

        // Asynchronous reset in WAIT discards the transaction.
        bus.req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("pre_rst_en", 32'(bus.en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(bus.en), 32'd0);
        chk("arst_din", 32'(bus.din_rvs), 32'd1);
        chk("arst_gnt", 32'(bus.gnt), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        bus.req = 4'b1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{done: 4'b1000, res: 1'b1});
        wait_done("post_rst_wait");
        chk("post_rst_done", 32'(bus.done), 32'h8);
        bus.req = '0;
        @(negedge clk);

        do_reset();
        bus.req = 4'b1001;
        sb_q.push_back('{done: 4'b0001, res: 1'b1});
        @(negedge clk);
        chk("tie_gnt", 32'(bus.gnt), 32'h1);
        wait_done("tie_wait");
        chk("tie_done", 32'(bus.done), 32'h1);
        bus.req = '0;
        repeat (2) @(negedge clk);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
